// File: rtl/lcd_timing_pkg.sv
// Shared types, default 1024x600 panel timing and small elaboration helpers
// for the LCD timing generator.
package lcd_timing_pkg;

    typedef enum logic {
        MODE_HV = 1'b0,
        MODE_DE = 1'b1
    } mode_e;

    typedef struct packed {
        int sync;
        int bp;
        int active;
        int fp;
    } axis_timing_t;

    localparam int DEF_H_SYNC   = 20;
    localparam int DEF_H_BP     = 140;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 160;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 20;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 12;

    function automatic int axis_total(input axis_timing_t t);
        return t.sync + t.bp + t.active + t.fp;
    endfunction

    function automatic bit axis_valid(input axis_timing_t t);
        return (t.sync >= 1) && (t.bp >= 1) && (t.active >= 1) && (t.fp >= 1);
    endfunction

    // Keeps degenerate sizes (1 entry) at a legal one-bit width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Timing bundle between the generator (master) and the pixel pipeline /
// frame-buffer reader (slave): run controls in, syncs, coordinates and strobes out.
interface lcd_timing_gen_if import lcd_timing_pkg::*; #(
    parameter int XW = 10,
    parameter int YW = 10
) ();

    logic          en;
    mode_e         mode;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_start;
    logic          line_start;

    modport master (
        input  en, mode,
        output hsync, vsync, de, x, y, frame_start, line_start
    );

    modport slave (
        output en, mode,
        input  hsync, vsync, de, x, y, frame_start, line_start
    );

endinterface

// File: rtl/lcd_timing_axis.sv
// One timing axis: a counter that wraps explicitly at TOTAL-1 plus constant
// decodes for the sync pulse, the active window and the active position.
module lcd_timing_axis import lcd_timing_pkg::*; #(
    parameter  int SYNC   = 1,
    parameter  int BP     = 1,
    parameter  int ACTIVE = 1,
    parameter  int FP     = 1,
    localparam int TOTAL  = SYNC + BP + ACTIVE + FP,
    localparam int CW     = clog2_min1(TOTAL),
    localparam int PW     = clog2_min1(ACTIVE)
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync_act,
    output logic          act,
    output logic [PW-1:0] pos
);

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    localparam logic [CW-1:0] ACT_BEG  = CW'(SYNC + BP);
    localparam logic [CW-1:0] ACT_END  = CW'(SYNC + BP + ACTIVE);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (step) begin
            cnt_reg <= wrap ? '0 : cnt_reg + CW'(1);
        end
    end

    assign cnt      = cnt_reg;
    assign wrap     = (cnt_reg == LAST);
    assign sync_act = (cnt_reg < SYNC_END);
    assign act      = (cnt_reg >= ACT_BEG) && (cnt_reg < ACT_END);
    assign pos      = act ? PW'(cnt_reg - ACT_BEG) : '0;

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD timing generator: horizontal/vertical axis counters feed a
// registered output stage with runtime HV / DE-only mode and per-signal polarity.
module lcd_timing_gen import lcd_timing_pkg::*; #(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter bit DE_POL   = 1'b1
) (
    input  logic              clock,
    input  logic              reset_L,
    lcd_timing_gen_if.master  bus
);

    localparam axis_timing_t H_T = '{sync: H_SYNC, bp: H_BP, active: H_ACTIVE, fp: H_FP};
    localparam axis_timing_t V_T = '{sync: V_SYNC, bp: V_BP, active: V_ACTIVE, fp: V_FP};
    localparam int H_TOTAL = axis_total(H_T);
    localparam int V_TOTAL = axis_total(V_T);
    localparam int XW      = clog2_min1(H_ACTIVE);
    localparam int YW      = clog2_min1(V_ACTIVE);
    localparam int HCW     = clog2_min1(H_TOTAL);
    localparam int VCW     = clog2_min1(V_TOTAL);
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int GW      = clog2_min1(FRAME + 1);

    generate
        if (!axis_valid(H_T) || !axis_valid(V_T) || (H_TOTAL < 2)) begin : g_bad_params
            $fatal(1, "lcd_timing_gen: timing parameters must be >= 1 and H_TOTAL >= 2");
        end
    endgenerate

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_wrap, v_wrap, h_sync_act, v_sync_act, h_act, v_act;
    logic [XW-1:0]  h_pos;
    logic [YW-1:0]  v_pos;
    logic           axis_clear, v_step;

    assign axis_clear = ~bus.en;
    assign v_step     = bus.en & h_wrap;

    lcd_timing_axis #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h_axis (
        .clock(clock), .reset_L(reset_L), .clear(axis_clear), .step(bus.en),
        .cnt(h_cnt), .wrap(h_wrap), .sync_act(h_sync_act), .act(h_act), .pos(h_pos)
    );

    lcd_timing_axis #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v_axis (
        .clock(clock), .reset_L(reset_L), .clear(axis_clear), .step(v_step),
        .cnt(v_cnt), .wrap(v_wrap), .sync_act(v_sync_act), .act(v_act), .pos(v_pos)
    );

    logic          en_q_reg;
    mode_e         mode_q_reg;
    logic          hsync_reg, vsync_reg, de_reg, fs_reg, ls_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          first_edge, frame_wrap, in_active;
    mode_e         mode_eff;

    // The first enabled edge already emits position (0,0), so it must use the
    // freshly sampled mode rather than the stale mode_q.
    assign first_edge = bus.en & ~en_q_reg;
    assign frame_wrap = h_wrap & v_wrap;
    assign mode_eff   = first_edge ? bus.mode : mode_q_reg;
    assign in_active  = h_act & v_act;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            en_q_reg   <= 1'b0;
            mode_q_reg <= MODE_HV;
            hsync_reg  <= ~HS_POL;
            vsync_reg  <= ~VS_POL;
            de_reg     <= ~DE_POL;
            x_reg      <= '0;
            y_reg      <= '0;
            fs_reg     <= 1'b0;
            ls_reg     <= 1'b0;
        end else begin
            en_q_reg <= bus.en;
            if (!bus.en) begin
                hsync_reg <= ~HS_POL;
                vsync_reg <= ~VS_POL;
                de_reg    <= ~DE_POL;
                x_reg     <= '0;
                y_reg     <= '0;
                fs_reg    <= 1'b0;
                ls_reg    <= 1'b0;
            end else begin
                if (first_edge || frame_wrap) begin
                    mode_q_reg <= bus.mode;
                end
                hsync_reg <= ((mode_eff == MODE_HV) && h_sync_act) ? HS_POL : ~HS_POL;
                vsync_reg <= ((mode_eff == MODE_HV) && v_sync_act) ? VS_POL : ~VS_POL;
                de_reg    <= in_active ? DE_POL : ~DE_POL;
                x_reg     <= in_active ? h_pos : '0;
                y_reg     <= in_active ? v_pos : '0;
                fs_reg    <= (h_cnt == '0) && (v_cnt == '0);
                ls_reg    <= (h_cnt == '0);
            end
        end
    end

    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.de          = de_reg;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.frame_start = fs_reg;
    assign bus.line_start  = ls_reg;

    // Clocks since the last frame_start; restarts whenever the generator is disabled.
    logic [GW-1:0] fs_gap_reg;
    logic          fs_seen_reg;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            fs_gap_reg  <= '0;
            fs_seen_reg <= 1'b0;
        end else if (!bus.en) begin
            fs_gap_reg  <= '0;
            fs_seen_reg <= 1'b0;
        end else if (fs_reg) begin
            fs_gap_reg  <= GW'(1);
            fs_seen_reg <= 1'b1;
        end else begin
            fs_gap_reg  <= fs_gap_reg + GW'(1);
        end
    end

    a_de_in_range: assert property (@(posedge clock) disable iff (!reset_L)
        (de_reg == DE_POL) |-> ((32'(x_reg) < H_ACTIVE) && (32'(y_reg) < V_ACTIVE)));

    a_fs_implies_ls: assert property (@(posedge clock) disable iff (!reset_L)
        fs_reg |-> ls_reg);

    a_frame_period: assert property (@(posedge clock) disable iff (!reset_L)
        (fs_reg && fs_seen_reg) |-> (32'(fs_gap_reg) == FRAME));

endmodule
